regfile_mp_sb: RTL

//  Parametrised multi-port integer register file with built-in scoreboard and

---
 rtl/riscv_rf_pkg.sv | 27 ++
 rtl/rf_read_port.sv | 74 +++++++
 rtl/regfile_mp_sb.sv | 125 ++++++++++++
 3 files changed

// File: rtl/riscv_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_rf_pkg
//  Description : Shared constants, types and helpers for the integer register
//                file and its decode/writeback neighbours.
//                  RF_DATA_W_DEF   default register width
//                  RF_NUM_REGS_DEF default architectural register count
//                  rf_aw()         register-index width for a given count
//                  rf_idx_t        register index (default geometry)
//                  rf_word_t       data word (default geometry)
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_rf_pkg;

    localparam int RF_DATA_W_DEF   = 32;
    localparam int RF_NUM_REGS_DEF = 32;

    // Index width; a single register still needs one address bit.
    function automatic int rf_aw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [rf_aw(RF_NUM_REGS_DEF)-1:0] rf_idx_t;
    typedef logic [RF_DATA_W_DEF-1:0]          rf_word_t;

endpackage : riscv_rf_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : rf_read_port
//  Description : One combinational read port of the register file: storage
//                select, write-bypass priority mux, zero-register gating and
//                scoreboard busy lookup.
//  Ports       : i_addr       register to read
//                i_regs       flattened storage, reg r at [r*DATA_W +: DATA_W]
//                i_busy       scoreboard vector (bit 0 already masked if needed)
//                i_wr_ok      qualified write enables (zero-reg writes removed)
//                i_wr_addr    write addresses, port p at [p*AW +: AW]
//                i_wr_data    write data, port p at [p*DATA_W +: DATA_W]
//                i_issue_ok   qualified issue enable
//                i_issue_addr issue destination
//                o_data       read data
//                o_busy       busy bit of the addressed register
//  Revision    : 1.0  initial release
// ============================================================================
module rf_read_port
    import riscv_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int NUM_REGS = RF_NUM_REGS_DEF,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = rf_aw(NUM_REGS)
)(
    input  logic [AW-1:0]            i_addr,
    input  logic [NUM_REGS*DATA_W-1:0] i_regs,
    input  logic [NUM_REGS-1:0]      i_busy,
    input  logic [NUM_WR-1:0]        i_wr_ok,
    input  logic [NUM_WR*AW-1:0]     i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic                     i_issue_ok,
    input  logic [AW-1:0]            i_issue_addr,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_busy
);

    logic              w_hit;
    logic [DATA_W-1:0] w_fwd_data;

    // Ascending scan so the highest-index matching write port wins.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (i_wr_ok[p] && (i_wr_addr[p*AW +: AW] == i_addr)) begin
                w_hit      = 1'b1;
                w_fwd_data = i_wr_data[p*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        o_data = i_regs[i_addr*DATA_W +: DATA_W];
        o_busy = i_busy[i_addr];
        if ((BYPASS != 0) && w_hit) begin
            o_data = w_fwd_data;
            // A new producer issued this cycle keeps the register pending
            // even though the retiring value is forwarded.
            if (!(i_issue_ok && (i_issue_addr == i_addr))) begin
                o_busy = 1'b0;
            end
        end
        if ((ZERO_REG != 0) && (i_addr == '0)) begin
            o_data = '0;
            o_busy = 1'b0;
        end
    end

endmodule : rf_read_port
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_sb
//  Description : Parametrised multi-port integer register file with per-
//                register busy scoreboard and optional write-to-read bypass.
//  Ports       : clk_i        clock
//                rst_i        synchronous active-high reset
//                rd_addr_i    read addresses, port k at [k*AW +: AW]
//                rd_data_o    read data, combinational
//                rd_busy_o    busy bit of each addressed register
//                wr_en_i      write enables
//                wr_addr_i    write addresses
//                wr_data_i    write data
//                issue_en_i   mark issue_addr_i pending
//                issue_addr_i destination of the newly issued instruction
//                busy_o       full scoreboard vector
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_mp_sb
    import riscv_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int NUM_REGS = RF_NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(NUM_REGS)
)(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     issue_en_i,
    input  logic [AW-1:0]            issue_addr_i,
    output logic [NUM_REGS-1:0]      busy_o
);

    logic [DATA_W-1:0]          r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]        r_busy;
    logic [NUM_WR-1:0]          w_wr_ok;
    logic                       w_issue_ok;
    logic [NUM_REGS*DATA_W-1:0] w_regs_flat;
    logic [NUM_REGS-1:0]        w_busy;

    // Writes and issues aimed at a hardwired zero register are dropped here,
    // so neither storage, scoreboard nor bypass ever sees them.
    always_comb begin
        w_wr_ok = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            w_wr_ok[p] = wr_en_i[p] &&
                         !((ZERO_REG != 0) && (wr_addr_i[p*AW +: AW] == '0));
        end
        w_issue_ok = issue_en_i && !((ZERO_REG != 0) && (issue_addr_i == '0));
    end

    // Later iterations override earlier ones: highest write port wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_ok[p]) begin
                    r_regs[wr_addr_i[p*AW +: AW]] <= wr_data_i[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Issue is applied after the write clears so a same-cycle issue to the
    // retiring register leaves it busy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_ok[p]) begin
                    r_busy[wr_addr_i[p*AW +: AW]] <= 1'b0;
                end
            end
            if (w_issue_ok) begin
                r_busy[issue_addr_i] <= 1'b1;
            end
        end
    end

    assign w_busy = (ZERO_REG != 0) ? {r_busy[NUM_REGS-1:1], 1'b0} : r_busy;
    assign busy_o = w_busy;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
            assign w_regs_flat[i*DATA_W +: DATA_W] = r_regs[i];
        end

        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            rf_read_port #(
                .DATA_W   (DATA_W),
                .NUM_REGS (NUM_REGS),
                .NUM_WR   (NUM_WR),
                .BYPASS   (BYPASS),
                .ZERO_REG (ZERO_REG),
                .AW       (AW)
            ) u_rd (
                .i_addr       (rd_addr_i[k*AW +: AW]),
                .i_regs       (w_regs_flat),
                .i_busy       (w_busy),
                .i_wr_ok      (w_wr_ok),
                .i_wr_addr    (wr_addr_i),
                .i_wr_data    (wr_data_i),
                .i_issue_ok   (w_issue_ok),
                .i_issue_addr (issue_addr_i),
                .o_data       (rd_data_o[k*DATA_W +: DATA_W]),
                .o_busy       (rd_busy_o[k])
            );
        end
    endgenerate

endmodule : regfile_mp_sb
`default_nettype wire
